sprite_fetch_arbiter: RTL and testbench



---
 rtl/sprite_fetch_arbiter.sv | 251 +++++++++++++++++++++++++
 tb/tb_sprite_fetch_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// sprite_fetch_arbiter
//
// Purpose:
//   Shares one single-port sprite ROM between NUM_REQ draw layers. On each
//   pixel_strobe the on-flags and ROM addresses of all layers are captured.
//   The on-layers are then read in fixed priority order (layer 0 first).
//   Transparent texels are skipped. The first opaque palette index, together
//   with its layer ID, is returned as a one-cycle result pulse. When no layer
//   is opaque, the result is the background (index TRANSP_IDX, layer
//   NUM_REQ). If a new strobe arrives before the current pixel has resolved,
//   the current pixel is aborted and flagged as an overrun.
//
// Ports:
//   Clk50          in   system clock
//   Reset          in   synchronous, active-high reset
//   pixel_strobe   in   one-cycle pulse, request inputs valid for a new pixel
//   req_on         in   [NUM_REQ]         per-layer "inside sprite" flag
//   req_addr       in   [NUM_REQ*ADDR_W]  per-layer ROM address, layer k at
//                                         bits [k*ADDR_W +: ADDR_W]
//   rom_rd         out  ROM read enable
//   rom_addr       out  [ADDR_W]  ROM address, holds its value between reads
//   rom_data       in   [DATA_W]  ROM output, valid ROM_LAT cycles after rom_rd
//   pix_valid      out  one-cycle result pulse
//   pix_index      out  [DATA_W]  winning palette index
//   pix_layer      out  [LAYER_W] winning layer, NUM_REQ means background
//   pix_overrun    out  qualifies pix_valid: the result was forced by an overrun
//   overrun_count  out  [16] saturating overrun counter
//
// Build option:
//   SPRITE_ARB_OVERRUN_CNT_EN - when defined, overrun_count counts overrun
//   pulses and saturates at 16'hFFFF. When undefined, overrun_count is 0 and
//   the counter is not built.
// ---------------------------------------------------------------------------
module sprite_fetch_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 4,
  parameter int ROM_LAT    = 1,
  parameter int TRANSP_IDX = 0,
  parameter int LAYER_W    = 3
) (
  input  logic                      Clk50,
  input  logic                      Reset,
  input  logic                      pixel_strobe,
  input  logic [NUM_REQ-1:0]        req_on,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic                      rom_rd,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic                      pix_valid,
  output logic [DATA_W-1:0]         pix_index,
  output logic [LAYER_W-1:0]        pix_layer,
  output logic                      pix_overrun,
  output logic [15:0]               overrun_count
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WAIT_W = 2;

  localparam logic [DATA_W-1:0]  TRANSP = DATA_W'(TRANSP_IDX);
  localparam logic [LAYER_W-1:0] BG_LAYER = LAYER_W'(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_DONE_BG
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  pend_q, pend_d;
  logic [IDX_W-1:0]    cur_q, cur_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [ADDR_W-1:0]   addr_hold_q, addr_hold_d;
  logic                pix_valid_q, pix_valid_d;
  logic [DATA_W-1:0]   pix_index_q, pix_index_d;
  logic [LAYER_W-1:0]  pix_layer_q, pix_layer_d;
  logic                pix_overrun_q, pix_overrun_d;

  logic [ADDR_W-1:0]   bank_q [NUM_REQ];
  logic [ADDR_W-1:0]   req_addr_a [NUM_REQ];
  logic                capture;
  logic                issue_rd;
  logic [IDX_W-1:0]    first_sel;
  logic [NUM_REQ-1:0]  pend_left;

  // Unpack the flat address bus into one entry per layer.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_addr_a[gi] = req_addr[gi*ADDR_W +: ADDR_W];
  end

  // Lowest set bit of the pending mask is the highest-priority layer left.
  always_comb begin
    first_sel = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pend_q[i]) first_sel = IDX_W'(i);
    end
  end

  // Mask with the layer just read removed, used when its texel is transparent.
  assign pend_left = pend_q & ~(NUM_REQ'(1) << cur_q);

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    cur_d         = cur_q;
    wait_d        = wait_q;
    addr_hold_d   = addr_hold_q;
    pix_valid_d   = 1'b0;
    pix_overrun_d = 1'b0;
    pix_index_d   = pix_index_q;
    pix_layer_d   = pix_layer_q;
    capture       = 1'b0;
    issue_rd      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pixel_strobe) begin
          capture = 1'b1;
          pend_d  = req_on;
          state_d = S_ISSUE;
        end
      end

      // An empty captured mask is resolved here without a ROM read, which
      // places the background result two cycles after its strobe.
      S_ISSUE: begin
        if (pend_q != '0) begin
          issue_rd    = 1'b1;
          cur_d       = first_sel;
          addr_hold_d = bank_q[first_sel];
          wait_d      = WAIT_W'(ROM_LAT - 1);
          state_d     = S_WAIT;
        end else begin
          state_d     = S_DONE_BG;
          pix_valid_d = 1'b1;
          pix_index_d = TRANSP;
          pix_layer_d = BG_LAYER;
        end
      end

      S_WAIT: begin
        if (wait_q != '0) begin
          wait_d = wait_q - WAIT_W'(1);
        end else if (rom_data != TRANSP) begin
          state_d     = S_DONE;
          pix_valid_d = 1'b1;
          pix_index_d = rom_data;
          pix_layer_d = LAYER_W'(cur_q);
        end else begin
          pend_d = pend_left;
          if (pend_left != '0) begin
            state_d = S_ISSUE;
          end else begin
            state_d     = S_DONE_BG;
            pix_valid_d = 1'b1;
            pix_index_d = TRANSP;
            pix_layer_d = BG_LAYER;
          end
        end
      end

      // The result is already on the outputs during this cycle, so a new
      // strobe here simply starts the next pixel.
      S_DONE, S_DONE_BG: begin
        state_d = S_IDLE;
        if (pixel_strobe) begin
          capture = 1'b1;
          pend_d  = req_on;
          state_d = S_ISSUE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A strobe while a pixel is still being resolved aborts that pixel. Any
    // read still in flight is dropped because the walk restarts at ISSUE.
    if (pixel_strobe && (state_q == S_ISSUE || state_q == S_WAIT)) begin
      capture       = 1'b1;
      pend_d        = req_on;
      state_d       = S_ISSUE;
      pix_valid_d   = 1'b1;
      pix_overrun_d = 1'b1;
      pix_index_d   = TRANSP;
      pix_layer_d   = BG_LAYER;
    end
  end

  always_ff @(posedge Clk50) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      pend_q        <= '0;
      cur_q         <= '0;
      wait_q        <= '0;
      addr_hold_q   <= '0;
      pix_valid_q   <= 1'b0;
      pix_index_q   <= '0;
      pix_layer_q   <= '0;
      pix_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      cur_q         <= cur_d;
      wait_q        <= wait_d;
      addr_hold_q   <= addr_hold_d;
      pix_valid_q   <= pix_valid_d;
      pix_index_q   <= pix_index_d;
      pix_layer_q   <= pix_layer_d;
      pix_overrun_q <= pix_overrun_d;
    end
  end

  // Address bank is pure data; it is only consumed after a capture.
  always_ff @(posedge Clk50) begin
    if (capture) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        bank_q[i] <= req_addr_a[i];
      end
    end
  end

  assign rom_rd      = issue_rd;
  assign rom_addr    = issue_rd ? bank_q[first_sel] : addr_hold_q;
  assign pix_valid   = pix_valid_q;
  assign pix_index   = pix_index_q;
  assign pix_layer   = pix_layer_q;
  assign pix_overrun = pix_overrun_q;

`ifdef SPRITE_ARB_OVERRUN_CNT_EN
  logic [15:0] ovr_cnt_q, ovr_cnt_d;

  // Counts together with the pulse so the value is current while it is shown.
  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (pix_overrun_d && ovr_cnt_q != 16'hFFFF) ovr_cnt_d = ovr_cnt_q + 16'd1;
  end

  always_ff @(posedge Clk50) begin
    if (Reset) ovr_cnt_q <= '0;
    else       ovr_cnt_q <= ovr_cnt_d;
  end

  assign overrun_count = ovr_cnt_q;
`else
  assign overrun_count = 16'h0000;
`endif

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sprite_fetch_arbiter
//
// Drives pixel strobes into sprite_fetch_arbiter with a one-cycle-latency ROM
// model. Each stimulus pushes the ROM reads and pixel results it should
// produce (with their absolute cycle numbers) into scoreboard queues; a
// monitor on the falling edge pops and compares them as the DUT produces
// rom_rd and pix_valid.
// ---------------------------------------------------------------------------
module tb_sprite_fetch_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 18;
  localparam int DATA_W  = 4;
  localparam int LAYER_W = 3;

`ifdef SPRITE_ARB_OVERRUN_CNT_EN
  localparam int EXP_OVR_CNT = 1;
`else
  localparam int EXP_OVR_CNT = 0;
`endif

  logic                      Clk50 = 1'b0;
  logic                      Reset = 1'b1;
  logic                      pixel_strobe = 1'b0;
  logic [NUM_REQ-1:0]        req_on = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic                      rom_rd;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DATA_W-1:0]         rom_data = '0;
  logic                      pix_valid;
  logic [DATA_W-1:0]         pix_index;
  logic [LAYER_W-1:0]        pix_layer;
  logic                      pix_overrun;
  logic [15:0]               overrun_count;

  sprite_fetch_arbiter dut (
    .Clk50         (Clk50),
    .Reset         (Reset),
    .pixel_strobe  (pixel_strobe),
    .req_on        (req_on),
    .req_addr      (req_addr),
    .rom_rd        (rom_rd),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .pix_valid     (pix_valid),
    .pix_index     (pix_index),
    .pix_layer     (pix_layer),
    .pix_overrun   (pix_overrun),
    .overrun_count (overrun_count)
  );

  typedef struct {
    int cyc;
    int addr;
  } rd_exp_t;

  typedef struct {
    int cyc;
    int idx;
    int layer;
    int ovr;
  } px_exp_t;

  rd_exp_t             rd_q[$];
  px_exp_t             px_q[$];
  logic [DATA_W-1:0]   rom_mem [int];
  int                  cyc = 0;
  int                  n_checks = 0;
  int                  n_fail = 0;

  always #10 Clk50 = ~Clk50;

  always @(posedge Clk50) cyc <= cyc + 1;

  // ROM model: unknown addresses return an opaque 0xF so a wrong address
  // shows up as a wrong result.
  always @(posedge Clk50) begin
    if (rom_rd) rom_data <= rom_mem.exists(int'(rom_addr)) ? rom_mem[int'(rom_addr)] : 4'hF;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge Clk50) begin
    if (rom_rd) begin
      check_eq("rd_expected", 32'(rd_q.size() != 0), 32'd1);
      if (rd_q.size() != 0) begin
        rd_exp_t e;
        e = rd_q.pop_front();
        check_eq("rd_cycle", 32'(cyc), 32'(e.cyc));
        check_eq("rd_addr", 32'(rom_addr), 32'(e.addr));
        $display("read  cyc=%0d addr=%0d (exp cyc=%0d addr=%0d)", cyc, rom_addr, e.cyc, e.addr);
      end
    end
    if (pix_valid) begin
      check_eq("px_expected", 32'(px_q.size() != 0), 32'd1);
      if (px_q.size() != 0) begin
        px_exp_t p;
        p = px_q.pop_front();
        check_eq("px_cycle", 32'(cyc), 32'(p.cyc));
        check_eq("px_index", 32'(pix_index), 32'(p.idx));
        check_eq("px_layer", 32'(pix_layer), 32'(p.layer));
        check_eq("px_overrun", 32'(pix_overrun), 32'(p.ovr));
        $display("pixel cyc=%0d idx=%0d layer=%0d ovr=%0d (exp cyc=%0d idx=%0d layer=%0d ovr=%0d)",
                 cyc, pix_index, pix_layer, pix_overrun, p.cyc, p.idx, p.layer, p.ovr);
      end
    end
  end

  // Present one strobe cycle, then scramble the inputs to show they are
  // captured. Returns the cycle number of the strobe.
  task automatic drive_px(input logic [NUM_REQ-1:0] on, input int a0, input int a1,
                          input int a2, input int a3, output int t);
    @(posedge Clk50); #1;
    pixel_strobe = 1'b1;
    req_on       = on;
    req_addr[0*ADDR_W +: ADDR_W] = ADDR_W'(a0);
    req_addr[1*ADDR_W +: ADDR_W] = ADDR_W'(a1);
    req_addr[2*ADDR_W +: ADDR_W] = ADDR_W'(a2);
    req_addr[3*ADDR_W +: ADDR_W] = ADDR_W'(a3);
    t = cyc;
    @(posedge Clk50); #1;
    pixel_strobe = 1'b0;
    req_on       = NUM_REQ'($urandom);
    for (int k = 0; k < NUM_REQ; k++) req_addr[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
  endtask

  task automatic exp_rd(input int c, input int a);
    rd_exp_t e;
    e.cyc = c; e.addr = a;
    rd_q.push_back(e);
  endtask

  task automatic exp_px(input int c, input int idx, input int layer, input int ovr);
    px_exp_t p;
    p.cyc = c; p.idx = idx; p.layer = layer; p.ovr = ovr;
    px_q.push_back(p);
  endtask

  // Bounded drain: everything expected must have appeared by now.
  task automatic settle(input string tag);
    repeat (14) @(posedge Clk50);
    #1;
    check_eq({tag, "_rd_left"}, 32'(rd_q.size()), 32'd0);
    check_eq({tag, "_px_left"}, 32'(px_q.size()), 32'd0);
    rd_q.delete();
    px_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_rom_rd"}, 32'(rom_rd), 32'd0);
    check_eq({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check_eq({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check_eq({tag, "_pix_index"}, 32'(pix_index), 32'd0);
    check_eq({tag, "_pix_layer"}, 32'(pix_layer), 32'd0);
    check_eq({tag, "_pix_overrun"}, 32'(pix_overrun), 32'd0);
    check_eq({tag, "_ovr_cnt"}, 32'(overrun_count), 32'd0);
  endtask

  initial begin
    int t, t2;

    rom_mem[191323] = 4'd3;
    rom_mem[5000]   = 4'd9;
    rom_mem[1000]   = 4'd0;
    rom_mem[46904]  = 4'd7;
    rom_mem[10] = 4'd0; rom_mem[20] = 4'd0; rom_mem[30] = 4'd0; rom_mem[40] = 4'd0;
    rom_mem[50] = 4'd0; rom_mem[60] = 4'd0; rom_mem[70] = 4'd0; rom_mem[80] = 4'd0;
    rom_mem[12345]  = 4'd6;
    rom_mem[600]    = 4'd5;
    rom_mem[700]    = 4'd9;
    rom_mem[300]    = 4'hA;
    rom_mem[400]    = 4'hB;

    repeat (3) @(posedge Clk50);
    @(negedge Clk50);
    check_idle_outputs("reset");
    @(posedge Clk50); #1;
    Reset = 1'b0;

    // First layer opaque; layer 2 also opaque but lower priority.
    drive_px(4'b0101, 191323, 77, 5000, 88, t);
    exp_rd(t + 1, 191323);
    exp_px(t + 3, 3, 0, 0);
    settle("first_opaque");

    // Layer 0 transparent, falls back to layer 1.
    drive_px(4'b0011, 1000, 46904, 9, 9, t);
    exp_rd(t + 1, 1000);
    exp_rd(t + 3, 46904);
    exp_px(t + 5, 7, 1, 0);
    settle("fallback");

    // No layer on: background without any read.
    drive_px(4'b0000, 191323, 46904, 5000, 600, t);
    exp_px(t + 2, 0, 4, 0);
    settle("empty");

    // All four layers transparent.
    drive_px(4'b1111, 10, 20, 30, 40, t);
    exp_rd(t + 1, 10);
    exp_rd(t + 3, 20);
    exp_rd(t + 5, 30);
    exp_rd(t + 7, 40);
    exp_px(t + 9, 0, 4, 0);
    settle("all_transp");

    // Both layers opaque: lower index wins.
    drive_px(4'b0110, 1, 600, 700, 2, t);
    exp_rd(t + 1, 600);
    exp_px(t + 3, 5, 1, 0);
    settle("priority");

    // Overrun: second strobe two cycles into a four-layer walk.
    drive_px(4'b1111, 50, 60, 70, 80, t);
    exp_rd(t + 1, 50);
    drive_px(4'b0100, 1, 2, 12345, 3, t2);
    check_eq("ovr_strobe_cycle", 32'(t2), 32'(t + 2));
    exp_px(t + 3, 0, 4, 1);
    exp_rd(t + 3, 12345);
    exp_px(t + 5, 6, 2, 0);
    settle("overrun");
    check_eq("ovr_count", 32'(overrun_count), 32'(EXP_OVR_CNT));

    // Strobe in the DONE cycle is not an overrun.
    drive_px(4'b0001, 300, 1, 2, 3, t);
    exp_rd(t + 1, 300);
    exp_px(t + 3, 10, 0, 0);
    @(posedge Clk50);
    drive_px(4'b0010, 1, 400, 2, 3, t2);
    check_eq("done_strobe_cycle", 32'(t2), 32'(t + 3));
    exp_rd(t + 4, 400);
    exp_px(t + 6, 11, 1, 0);
    settle("strobe_in_done");

    // Reset while waiting on the ROM: read happens, no result follows.
    drive_px(4'b0101, 191323, 77, 5000, 88, t);
    exp_rd(t + 1, 191323);
    @(posedge Clk50); #1;
    Reset = 1'b1;
    @(posedge Clk50); #1;
    Reset = 1'b0;
    @(negedge Clk50);
    check_idle_outputs("reset_wait");
    settle("reset_wait");

    // After reset the same pixel behaves as the first one.
    drive_px(4'b0101, 191323, 77, 5000, 88, t);
    exp_rd(t + 1, 191323);
    exp_px(t + 3, 3, 0, 0);
    settle("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
